// File: rtl/exe_alu_branch_unit_pkg.sv
// Shared constants for the EXE-stage ALU/branch slice: data width and alu_op encodings.
// Optional shifter support is selected by the ALU_SHIFT_EN macro in the ALU core.
package exe_alu_branch_unit_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_AND  = 4'h0,
    ALU_OR   = 4'h1,
    ALU_XOR  = 4'h2,
    ALU_NOR  = 4'h3,
    ALU_ADD  = 4'h4,
    ALU_ADDU = 4'h5,
    ALU_SUB  = 4'h6,
    ALU_SUBU = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9,
    ALU_SLL  = 4'hA,
    ALU_SRL  = 4'hB,
    ALU_SRA  = 4'hC,
    ALU_LUI  = 4'hD
  } alu_op_e;

endpackage

// File: rtl/exe_alu_branch_unit_core.sv
// Combinational 32-bit ALU: result, zero and signed-overflow flags.
// Macro ALU_SHIFT_EN adds SLL/SRL/SRA; without it those codes act as reserved (result 0).
module exe_alu_core
  import exe_alu_branch_unit_pkg::*;
(
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [OP_W-1:0]   alu_op,
  input  logic [4:0]        shamt,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              overflow
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;

  assign sum  = op1 + op2;
  assign diff = op1 - op2;

`ifndef ALU_SHIFT_EN
  logic unused_shamt;
  assign unused_shamt = ^shamt;
`endif

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (alu_op)
      ALU_AND:  result = op1 & op2;
      ALU_OR:   result = op1 | op2;
      ALU_XOR:  result = op1 ^ op2;
      ALU_NOR:  result = ~(op1 | op2);
      // Signed overflow: operands' sign relation vs. the sign of the result.
      ALU_ADD: begin
        result   = sum;
        overflow = (op1[31] == op2[31]) && (sum[31] != op1[31]);
      end
      ALU_ADDU: result = sum;
      ALU_SUB: begin
        result   = diff;
        overflow = (op1[31] != op2[31]) && (diff[31] != op1[31]);
      end
      ALU_SUBU: result = diff;
      ALU_SLT:  result = {31'b0, $signed(op1) < $signed(op2)};
      ALU_SLTU: result = {31'b0, op1 < op2};
`ifdef ALU_SHIFT_EN
      ALU_SLL:  result = op2 << shamt;
      ALU_SRL:  result = op2 >> shamt;
      ALU_SRA:  result = $signed(op2) >>> shamt;
`endif
      ALU_LUI:  result = {op2[15:0], 16'h0000};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/exe_alu_branch_unit.sv
// EXE-stage block: ALU core, branch-target adder and branch-taken decision, all registered.
// Shifter ops are present only when ALU_SHIFT_EN is defined.
module exe_alu_branch_unit
  import exe_alu_branch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [OP_W-1:0]   alu_op,
  input  logic [4:0]        shamt,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic [DATA_W-1:0] branch_imm,
  input  logic              branch_eq,
  input  logic              branch_ne,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero,
  output logic              overflow,
  output logic [DATA_W-1:0] branch_target,
  output logic              pc_src
);

  logic [DATA_W-1:0] result_next;
  logic              zero_next;
  logic              overflow_next;
  logic [DATA_W-1:0] target_next;
  logic              taken_next;
  logic              unused_imm;

  exe_alu_core u_core (
    .op1      (op1),
    .op2      (op2),
    .alu_op   (alu_op),
    .shamt    (shamt),
    .result   (result_next),
    .zero     (zero_next),
    .overflow (overflow_next)
  );

  // Word offset becomes a byte offset; the top two offset bits fall off the shift.
  assign target_next = pc_plus4 + {branch_imm[29:0], 2'b00};
  assign unused_imm  = ^branch_imm[31:30];
  assign taken_next  = (branch_eq & zero_next) | (branch_ne & ~zero_next);

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_result    <= '0;
      zero          <= 1'b0;
      overflow      <= 1'b0;
      branch_target <= '0;
      pc_src        <= 1'b0;
    end else begin
      alu_result    <= result_next;
      zero          <= zero_next;
      overflow      <= overflow_next;
      branch_target <= target_next;
      pc_src        <= taken_next;
    end
  end

endmodule

// File: tb/tb_exe_alu_branch_unit.sv
// Directed self-checking bench for exe_alu_branch_unit; shift expectations follow ALU_SHIFT_EN.
module tb_exe_alu_branch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] op1, op2, pc_plus4, branch_imm;
  logic [3:0]  alu_op;
  logic [4:0]  shamt;
  logic        branch_eq, branch_ne;
  logic [31:0] alu_result, branch_target;
  logic        zero, overflow, pc_src;

  int checks   = 0;
  int failures = 0;

  exe_alu_branch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .op1           (op1),
    .op2           (op2),
    .alu_op        (alu_op),
    .shamt         (shamt),
    .pc_plus4      (pc_plus4),
    .branch_imm    (branch_imm),
    .branch_eq     (branch_eq),
    .branch_ne     (branch_ne),
    .alu_result    (alu_result),
    .zero          (zero),
    .overflow      (overflow),
    .branch_target (branch_target),
    .pc_src        (pc_src)
  );

  always #5 clk = ~clk;

  // Drive one ALU op, clock it in, and settle 1 time unit past the edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    op1    = a;
    op2    = b;
    alu_op = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    op1 = 32'd5; op2 = 32'd10; alu_op = 4'h4; shamt = 5'd0;
    pc_plus4 = 32'd100; branch_imm = 32'd1; branch_eq = 1'b0; branch_ne = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({alu_result, zero, overflow, branch_target, pc_src} !== 67'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got res=%h z=%b ov=%b tgt=%h pc_src=%b exp all 0",
               alu_result, zero, overflow, branch_target, pc_src);
    end
    reset = 1'b0;
    branch_ne = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (alu_result !== 32'd15 || zero !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL first_after_reset got res=%h z=%b ov=%b exp res=0000000f z=0 ov=0",
               alu_result, zero, overflow);
    end
  endtask

  task automatic test_arith;
    run_op(32'd3, 32'd5, 4'h6);
    checks++;
    if (alu_result !== 32'hFFFFFFFE || overflow !== 1'b0 || zero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sub_neg got res=%h ov=%b z=%b exp fffffffe 0 0", alu_result, overflow, zero);
    end
    run_op(32'h7FFFFFFF, 32'd1, 4'h4);
    checks++;
    if (alu_result !== 32'h80000000 || overflow !== 1'b1) begin
      failures++;
      $display("[TB] FAIL add_ovf got res=%h ov=%b exp 80000000 1", alu_result, overflow);
    end
    run_op(32'h7FFFFFFF, 32'd1, 4'h5);
    checks++;
    if (alu_result !== 32'h80000000 || overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL addu_noovf got res=%h ov=%b exp 80000000 0", alu_result, overflow);
    end
    run_op(32'h80000000, 32'd1, 4'h6);
    checks++;
    if (alu_result !== 32'h7FFFFFFF || overflow !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sub_ovf got res=%h ov=%b exp 7fffffff 1", alu_result, overflow);
    end
    run_op(32'h80000000, 32'd1, 4'h7);
    checks++;
    if (alu_result !== 32'h7FFFFFFF || overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL subu_noovf got res=%h ov=%b exp 7fffffff 0", alu_result, overflow);
    end
    run_op(32'hFFFFFFFF, 32'd1, 4'h4);
    checks++;
    if (alu_result !== 32'd0 || zero !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL add_wrap_zero got res=%h z=%b ov=%b exp 0 1 0", alu_result, zero, overflow);
    end
  endtask

  task automatic test_logic_compare;
    logic [31:0] exp_res [0:6];
    logic [3:0]  ops     [0:6];
    logic [31:0] a_vals  [0:6];
    logic [31:0] b_vals  [0:6];
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h8, 4'h9, 4'hD};
    a_vals = '{32'h0000F0F0, 32'h0000F0F0, 32'h0000F0F0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
    b_vals = '{32'h0000FF00, 32'h0000FF00, 32'h0000FF00, 32'h0, 32'd1, 32'd1, 32'h1234ABCD};
    exp_res = '{32'h0000F000, 32'h0000FFF0, 32'h00000FF0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hABCD0000};
    for (int i = 0; i < 7; i++) begin
      run_op(a_vals[i], b_vals[i], ops[i]);
      checks++;
      if (alu_result !== exp_res[i] || zero !== (exp_res[i] == 32'd0) || overflow !== 1'b0) begin
        failures++;
        $display("[TB] FAIL logic_op_%h got res=%h z=%b ov=%b exp %h", ops[i], alu_result, zero,
                 overflow, exp_res[i]);
      end
    end
    run_op(32'h12345678, 32'h9ABCDEF0, 4'hE);
    checks++;
    if (alu_result !== 32'd0 || zero !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reserved_e got res=%h z=%b ov=%b exp 0 1 0", alu_result, zero, overflow);
    end
  endtask

  task automatic test_shift;
    logic [31:0] exp_res [0:2];
`ifdef ALU_SHIFT_EN
    exp_res = '{32'h00000000, 32'h08000000, 32'hF8000000};
`else
    exp_res = '{32'h0, 32'h0, 32'h0};
`endif
    shamt = 5'd4;
    for (int i = 0; i < 3; i++) begin
      run_op(32'hFFFFFFFF, 32'h80000000, 4'hA + 4'(i));
      checks++;
      if (alu_result !== exp_res[i] || zero !== (exp_res[i] == 32'd0) || overflow !== 1'b0) begin
        failures++;
        $display("[TB] FAIL shift_%0d got res=%h z=%b exp %h", i, alu_result, zero, exp_res[i]);
      end
    end
`ifdef ALU_SHIFT_EN
    shamt = 5'd31;
    run_op(32'h0, 32'h00000003, 4'hA);
    checks++;
    if (alu_result !== 32'h80000000) begin
      failures++;
      $display("[TB] FAIL sll_31 got %h exp 80000000", alu_result);
    end
`endif
    shamt = 5'd0;
  endtask

  task automatic test_branch_target;
    pc_plus4 = 32'd204;
    branch_imm = 32'hFFFFFFFE;
    run_op(32'd1, 32'd1, 4'h4);
    checks++;
    if (branch_target !== 32'd196) begin
      failures++;
      $display("[TB] FAIL target_back got %0d exp 196", branch_target);
    end
    branch_imm = 32'd3;
    run_op(32'd1, 32'd1, 4'h4);
    checks++;
    if (branch_target !== 32'd216) begin
      failures++;
      $display("[TB] FAIL target_fwd got %0d exp 216", branch_target);
    end
    pc_plus4 = 32'hFFFFFFFC;
    branch_imm = 32'd2;
    run_op(32'd1, 32'd1, 4'h4);
    checks++;
    if (branch_target !== 32'd4 || overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL target_wrap got %h ov=%b exp 00000004 0", branch_target, overflow);
    end
  endtask

  task automatic test_pc_src;
    logic [31:0] b_vals [0:4];
    logic [1:0]  flags  [0:4];
    logic        exp_taken [0:4];
    b_vals    = '{32'd7, 32'd7, 32'd8, 32'd8, 32'd7};
    flags     = '{2'b10, 2'b01, 2'b01, 2'b00, 2'b11};
    exp_taken = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      branch_eq = flags[i][1];
      branch_ne = flags[i][0];
      run_op(32'd7, b_vals[i], 4'h6);
      checks++;
      if (pc_src !== exp_taken[i]) begin
        failures++;
        $display("[TB] FAIL pc_src_%0d got %b exp %b", i, pc_src, exp_taken[i]);
      end
    end
    branch_eq = 1'b0;
    branch_ne = 1'b0;
  endtask

  task automatic test_back_to_back;
    op1 = 32'd10; op2 = 32'd20; alu_op = 4'h4;
    @(posedge clk);
    #1;
    op1 = 32'd50; op2 = 32'd8; alu_op = 4'h6;
    checks++;
    if (alu_result !== 32'd30) begin
      failures++;
      $display("[TB] FAIL b2b_first got %0d exp 30", alu_result);
    end
    @(posedge clk);
    #1;
    checks++;
    if (alu_result !== 32'd42) begin
      failures++;
      $display("[TB] FAIL b2b_second got %0d exp 42", alu_result);
    end
    op1 = 32'd9; op2 = 32'd9; alu_op = 4'h1; branch_eq = 1'b1; reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({alu_result, zero, overflow, branch_target, pc_src} !== 67'd0) begin
      failures++;
      $display("[TB] FAIL midstream_reset got res=%h z=%b tgt=%h pc_src=%b exp all 0",
               alu_result, zero, branch_target, pc_src);
    end
    reset = 1'b0;
    branch_eq = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (alu_result !== 32'd9) begin
      failures++;
      $display("[TB] FAIL post_reset_or got %0d exp 9", alu_result);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic_compare();
    test_shift();
    test_branch_target();
    test_pc_src();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exe_alu_branch_unit.md
# exe_alu_branch_unit

Execute-stage datapath block of the 5-stage MIPS pipeline: a 32-bit integer ALU, a branch-target adder and the branch-taken decision logic. It sits between the ID/EXE and EXE/MEM pipeline registers. All outputs are registered, so results are presented one cycle after operands are sampled.

## Interface
Parameters:
- none (data width fixed at 32, operation code width fixed at 4)

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all output registers
- op1  input  32  ALU operand A (forwarded Rs value)
- op2  input  32  ALU operand B (forwarded Rt value or extended immediate)
- alu_op  input  4  operation select
- shamt  input  5  shift amount for immediate shifts
- pc_plus4  input  32  PC+4 of the instruction in EXE
- branch_imm  input  32  sign-extended 16-bit branch offset (word units)
- branch_eq  input  1  instruction is BEQ
- branch_ne  input  1  instruction is BNE
- alu_result  output  32  registered ALU result
- zero  output  1  registered, 1 when ALU result == 0
- overflow  output  1  registered signed overflow flag
- branch_target  output  32  registered pc_plus4 + (branch_imm << 2)
- pc_src  output  1  registered branch-taken select

## Operation
- alu_op encoding: 0x0 AND, 0x1 OR, 0x2 XOR, 0x3 NOR, 0x4 ADD, 0x5 ADDU, 0x6 SUB, 0x7 SUBU, 0x8 SLT (signed), 0x9 SLTU, 0xA SLL, 0xB SRL, 0xC SRA, 0xD LUI (op2[15:0] << 16), 0xE and 0xF reserved → result 0.
- Shifts operate on op2, shift amount = shamt; op1 unused.
- All arithmetic is modulo 2^32; SLT/SLTU result is 32'h0 or 32'h1.
- overflow = 1 only for ADD (0x4) and SUB (0x6) when signed result overflows (operands same sign/different sign rules); 0 for every other op including ADDU/SUBU.
- zero computed from the 32-bit result of the current op, for every op.
- branch_target = pc_plus4 + {branch_imm[29:0], 2'b00}, wraps modulo 2^32, never flags overflow.
- pc_src = (branch_eq & zero_next) | (branch_ne & ~zero_next), where zero_next is the combinational zero of the current cycle's result; branch_eq and branch_ne both high → taken regardless of zero.

## Timing
- Inputs sampled on rising clk; all five outputs update together one cycle later (latency 1, throughput 1 op/cycle, no handshake, no stall).
- reset high at a rising edge: alu_result=0, zero=0, overflow=0, branch_target=0, pc_src=0 on the following cycle, overriding inputs; reset mid-stream discards the in-flight op.
- After reset deasserts, first valid output appears one cycle after first sampled operands.
- No combinational path from inputs to outputs.

## Configuration
- ALU_SHIFT_EN: defined → ops 0xA, 0xB, 0xC implemented as above. Undefined → shifter omitted; 0xA–0xC behave as reserved (result 0, zero=1, overflow=0).

## Structure
- Shared package holds alu_op encoding constants (ALU_AND … ALU_LUI) and data width constant 32.
- One natural sub-module: exe_alu_core (combinational result/zero/overflow); branch adder and pc_src logic inline in the top module with output registers.

## Test plan
- reset held 2 cycles with op1=5, op2=10, alu_op=0x4 → all outputs 0; one cycle after release alu_result=15, zero=0, overflow=0.
- op1=3, op2=5, alu_op=0x6 → alu_result=0xFFFFFFFE (-2), overflow=0; op1=0x7FFFFFFF, op2=1, alu_op=0x4 → alu_result=0x80000000, overflow=1; same with 0x5 → overflow=0.
- op1=0xFFFFFFFF, op2=1: SLT → 1, SLTU → 0; op2=0x0000ABCD, LUI → 0xABCD0000; reserved 0xE → 0, zero=1.
- ALU_SHIFT_EN defined: op2=0x80000000, shamt=4: SLL → 0, SRL → 0x08000000, SRA → 0xF8000000; macro undefined → all 0.
- pc_plus4=204, branch_imm=0xFFFFFFFE → branch_target=196; branch_imm=3 → 216.
- op1=op2=7, SUB: branch_eq=1 → pc_src=1, branch_ne=1 only → pc_src=0; op1=7, op2=8 with branch_ne=1 → pc_src=1; both branch flags 0 → pc_src=0.
